sme_desc_scheduler: RTL and testbench
=====================================

// Module: sme_desc_scheduler
// PURPOSE
//  Shares ACCEL_COUNT Pigasus SME accelerators between packet descriptors arriving on one queue.
//  Dispatches each descriptor (packet-memory addr/len + 64b preamble state) to a free accelerator
//  via the read-DMA descriptor port, tracks it to completion, and returns tagged match results.
//  Sits between the core-side MMIO/descriptor FIFO and the accel_rd_dma_sp + pigasus_sme_wrapper pair.
// PARAMETERS
//  ACCEL_COUNT    4     number of SME accelerators (>=2)
//  ADDR_WIDTH     16    packet-memory byte address width
//  LEN_WIDTH      14    descriptor length width (bytes)
//  TAG_WIDTH      8     opaque descriptor tag returned with results
//  RULE_WIDTH     16    SME rule ID width
//  DRAIN_CYCLES   16    quiet cycles after tlast before a job is closed
//  TIMEOUT_CYCLES 4096  watchdog limit (SME_WATCHDOG_EN only)
// PORTS
//  clk                in   1                    clock
//  rst                in   1                    synchronous reset, active high
//  s_desc_addr/len    in   ADDR_WIDTH/LEN_WIDTH descriptor fields
//  s_desc_state       in   64                   preamble state for the SME
//  s_desc_tag         in   TAG_WIDTH            descriptor tag
//  s_desc_valid/ready in/out 1                  descriptor handshake
//  desc_accel_id      out  $clog2(ACCEL_COUNT)  DMA target accelerator
//  desc_addr/len      out  ADDR_WIDTH/LEN_WIDTH DMA descriptor
//  desc_valid         out  1                    1-cycle DMA descriptor strobe
//  desc_error         in   ACCEL_COUNT          DMA rejected descriptor (per accel)
//  accel_busy         in   ACCEL_COUNT          DMA streaming to accel
//  accel_done         in   ACCEL_COUNT          1-cycle pulse on tvalid&tlast
//  accel_init         out  ACCEL_COUNT          1-cycle reload pulse, one-hot
//  accel_state        out  64                   preamble state, valid with accel_init
//  accel_stop         out  ACCEL_COUNT          abort request (watchdog)
//  match_valid        in   ACCEL_COUNT          SME has a match pending
//  match_rule_id      in   ACCEL_COUNT*RULE_WIDTH  pending rule ID per accel
//  match_release      out  ACCEL_COUNT          1-cycle pop of pending match
//  m_res_tag/rule     out  TAG_WIDTH/RULE_WIDTH result fields
//  m_res_last/err     out  1/1                  final record of job / job errored
//  m_res_valid/ready  out/in 1                  result handshake
// BEHAVIOUR
//  Reset: all accel FSMs IDLE, RR pointers 0; every output 0 (s_desc_ready, desc_valid,
//   accel_init, accel_stop, match_release, m_res_valid and all data outputs). Reset mid-job
//   abandons it silently; no result emitted.
//  Per-accel FSM: IDLE -> ISSUE -> RUN -> DRAIN -> FINAL -> IDLE.
//  Dispatch: s_desc_ready = 1 iff some accel is IDLE and !accel_busy. On accept, round-robin pick
//   (lowest index >= dispatch pointer, wrapping); pointer := pick+1 mod ACCEL_COUNT.
//   Next cycle (ISSUE): desc_valid, accel_init[pick], accel_state driven for exactly 1 cycle;
//   tag latched per accel. Max one dispatch per cycle. Then RUN.
//  desc_error[i] in cycle after ISSUE: -> FINAL with err=1 (no data streamed).
//  RUN: accel_done[i] -> DRAIN, quiet counter cleared. DRAIN: counter increments each cycle
//   match_valid[i]=0 and no result of i pending; reset to 0 otherwise; reaching DRAIN_CYCLES -> FINAL.
//  Match: accel in RUN/DRAIN with match_valid[i] requests output. Results arbiter: round-robin
//   over requesters (match requests and FINAL records). When m_res slot empty or consumed
//   (valid&ready), winner loads m_res; match winner pulses match_release[i] same cycle, and is
//   not re-requested until match_valid[i] re-sampled one cycle later.
//  FINAL record: rule=0, last=1, err as set; loading it returns accel to IDLE.
//  m_res_* held stable while valid&!ready; throughput one record/cycle.
//  Simultaneous match_valid and accel_done: done latched, match served normally.
//  Exactly one last=1 record per accepted descriptor; records of one tag stay in order.
// CONFIGURATION
//  SME_WATCHDOG_EN defined: per-accel cycle counter active in RUN/DRAIN; at TIMEOUT_CYCLES
//   pulse accel_stop[i] 1 cycle, go FINAL with err=1. Undefined: no counters, accel_stop tied 0.
// TESTING
//  1 desc tag=0x11 len=64, accel0 match_rule_id=0x0042 once, done -> {0x11,0x0042,last0},
//    then {0x11,0,last1,err0}; match_release[0] pulses once.
//  2 5 back-to-back descs, ACCEL_COUNT=4, all busy -> ids 0,1,2,3; 5th stalls (ready=0) until
//    first FINAL loaded, then goes to freed accel.
//  3 desc_error[2] after ISSUE -> single record {tag,0,last1,err1}, accel 2 IDLE next.
//  4 m_res_ready=0 for 20 cycles while 3 accels match -> outputs stable; releases only on load;
//    RR order 0,1,2 after ready.
//  5 match_valid rises 10 cycles after done -> reported before last=1 (DRAIN restart).
//  6 SME_WATCHDOG_EN, TIMEOUT_CYCLES=64, no done -> accel_stop pulse at cycle 64, err=1 record;
//    rst mid-job -> all outputs 0 next cycle.

Source files
------------

// File: rtl/sme_desc_scheduler.sv
// sme_desc_scheduler: shares ACCEL_COUNT SME accelerators between descriptors arriving on one queue.
// Latency: accepted descriptor -> DMA strobe/accel_init one cycle later; result records are registered.
// Backpressure: s_desc_ready low while no accel is idle and DMA-free; m_res_* held while !m_res_ready.
// Optional build macro SME_WATCHDOG_EN adds a per-accel timeout that aborts a stuck job via accel_stop.
module sme_desc_scheduler #(
  parameter int ACCEL_COUNT    = 4,
  parameter int ADDR_WIDTH     = 16,
  parameter int LEN_WIDTH      = 14,
  parameter int TAG_WIDTH      = 8,
  parameter int RULE_WIDTH     = 16,
  parameter int DRAIN_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ADDR_WIDTH-1:0]             s_desc_addr,
  input  logic [LEN_WIDTH-1:0]              s_desc_len,
  input  logic [63:0]                       s_desc_state,
  input  logic [TAG_WIDTH-1:0]              s_desc_tag,
  input  logic                              s_desc_valid,
  output logic                              s_desc_ready,
  output logic [$clog2(ACCEL_COUNT)-1:0]    desc_accel_id,
  output logic [ADDR_WIDTH-1:0]             desc_addr,
  output logic [LEN_WIDTH-1:0]              desc_len,
  output logic                              desc_valid,
  input  logic [ACCEL_COUNT-1:0]            desc_error,
  input  logic [ACCEL_COUNT-1:0]            accel_busy,
  input  logic [ACCEL_COUNT-1:0]            accel_done,
  output logic [ACCEL_COUNT-1:0]            accel_init,
  output logic [63:0]                       accel_state,
  output logic [ACCEL_COUNT-1:0]            accel_stop,
  input  logic [ACCEL_COUNT-1:0]            match_valid,
  input  logic [ACCEL_COUNT*RULE_WIDTH-1:0] match_rule_id,
  output logic [ACCEL_COUNT-1:0]            match_release,
  output logic [TAG_WIDTH-1:0]              m_res_tag,
  output logic [RULE_WIDTH-1:0]             m_res_rule,
  output logic                              m_res_last,
  output logic                              m_res_err,
  output logic                              m_res_valid,
  input  logic                              m_res_ready
);

  localparam int IDW = $clog2(ACCEL_COUNT);
  localparam int CW  = $clog2(DRAIN_CYCLES + 1);
  localparam logic [ACCEL_COUNT-1:0] ONE = {{(ACCEL_COUNT-1){1'b0}}, 1'b1};

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_FINAL = 3'd4;

  // per-accel job state
  logic [2:0]           st_q   [ACCEL_COUNT];
  logic [2:0]           st_d   [ACCEL_COUNT];
  logic [TAG_WIDTH-1:0] tag_q  [ACCEL_COUNT];
  logic [TAG_WIDTH-1:0] tag_d  [ACCEL_COUNT];
  logic                 err_q  [ACCEL_COUNT];
  logic                 err_d  [ACCEL_COUNT];
  logic [CW-1:0]        dcnt_q [ACCEL_COUNT];
  logic [CW-1:0]        dcnt_d [ACCEL_COUNT];
  logic [ACCEL_COUNT-1:0] blk_q;

  // dispatch and result-path registers
  logic [IDW-1:0]         ptr_q, rptr_q, res_src_q;
  logic                   desc_valid_q;
  logic [IDW-1:0]         desc_id_q;
  logic [ADDR_WIDTH-1:0]  desc_addr_q;
  logic [LEN_WIDTH-1:0]   desc_len_q;
  logic [ACCEL_COUNT-1:0] accel_init_q;
  logic [63:0]            accel_state_q;
  logic [TAG_WIDTH-1:0]   res_tag_q;
  logic [RULE_WIDTH-1:0]  res_rule_q;
  logic                   res_last_q, res_err_q, res_valid_q;

  logic [ACCEL_COUNT-1:0] free, req, res_pend, stop_d;
  logic                   pick_vld, gnt_vld, gnt_final, accept, res_load;
  logic [IDW-1:0]         pick_id, gnt_id;

`ifdef SME_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0]          wd_q [ACCEL_COUNT];
  logic [WW-1:0]          wd_d [ACCEL_COUNT];
  logic [ACCEL_COUNT-1:0] stop_q;
`endif

  // Classify accels: free for dispatch, requesting the result slot, or owning the held record.
  always_comb begin
    free     = '0;
    req      = '0;
    res_pend = '0;
    for (int i = 0; i < ACCEL_COUNT; i++) begin
      free[i]     = (st_q[i] == ST_IDLE) && !accel_busy[i];
      req[i]      = (st_q[i] == ST_FINAL) ||
                    (((st_q[i] == ST_RUN) || (st_q[i] == ST_DRAIN)) && match_valid[i] && !blk_q[i]);
      res_pend[i] = res_valid_q && (res_src_q == IDW'(i));
    end
  end

  // Round-robin pick of a free accel (dispatch) and of a requester (result slot).
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    gnt_vld  = 1'b0;
    gnt_id   = '0;
    for (int off = 0; off < ACCEL_COUNT; off++) begin
      if (!pick_vld && free[(int'(ptr_q) + off) % ACCEL_COUNT]) begin
        pick_vld = 1'b1;
        pick_id  = IDW'((int'(ptr_q) + off) % ACCEL_COUNT);
      end
      if (!gnt_vld && req[(int'(rptr_q) + off) % ACCEL_COUNT]) begin
        gnt_vld = 1'b1;
        gnt_id  = IDW'((int'(rptr_q) + off) % ACCEL_COUNT);
      end
    end
  end

  assign s_desc_ready  = pick_vld && !rst;
  assign accept        = s_desc_valid && s_desc_ready;
  assign res_load      = (!res_valid_q || m_res_ready) && !rst;
  assign gnt_final     = (st_q[gnt_id] == ST_FINAL);
  assign match_release = (res_load && gnt_vld && !gnt_final) ? (ONE << gnt_id) : '0;

  // Per-accel job FSM next state: dispatch, run, drain until quiet, then emit the final record.
  always_comb begin
    stop_d = '0;
    for (int i = 0; i < ACCEL_COUNT; i++) begin
      st_d[i]   = st_q[i];
      tag_d[i]  = tag_q[i];
      err_d[i]  = err_q[i];
      dcnt_d[i] = dcnt_q[i];
      case (st_q[i])
        ST_IDLE: begin
          if (accept && (pick_id == IDW'(i))) begin
            st_d[i]  = ST_ISSUE;
            tag_d[i] = s_desc_tag;
            err_d[i] = 1'b0;
          end
        end
        ST_ISSUE: st_d[i] = ST_RUN;
        ST_RUN: begin
          if (desc_error[i]) begin
            st_d[i]  = ST_FINAL;
            err_d[i] = 1'b1;
          end else if (accel_done[i]) begin
            st_d[i]   = ST_DRAIN;
            dcnt_d[i] = '0;
          end
        end
        ST_DRAIN: begin
          // a pending or in-flight match restarts the quiet window
          if (!match_valid[i] && !res_pend[i]) begin
            if (dcnt_q[i] == CW'(DRAIN_CYCLES - 1)) st_d[i] = ST_FINAL;
            else dcnt_d[i] = dcnt_q[i] + 1'b1;
          end else begin
            dcnt_d[i] = '0;
          end
        end
        ST_FINAL: begin
          if (res_load && gnt_vld && (gnt_id == IDW'(i))) st_d[i] = ST_IDLE;
        end
        default: st_d[i] = ST_IDLE;
      endcase
`ifdef SME_WATCHDOG_EN
      // counter runs from dispatch; only a job still streaming or draining can time out
      wd_d[i] = (st_q[i] == ST_IDLE) ? '0 : wd_q[i] + 1'b1;
      if (((st_q[i] == ST_RUN) || (st_q[i] == ST_DRAIN)) && (wd_q[i] == WW'(TIMEOUT_CYCLES - 1))) begin
        st_d[i]   = ST_FINAL;
        err_d[i]  = 1'b1;
        stop_d[i] = 1'b1;
      end
`endif
    end
  end

  // Per-accel state registers; release blocks re-request for one cycle while the SME pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ACCEL_COUNT; i++) begin
        st_q[i]   <= ST_IDLE;
        tag_q[i]  <= '0;
        err_q[i]  <= 1'b0;
        dcnt_q[i] <= '0;
      end
      blk_q <= '0;
    end else begin
      for (int i = 0; i < ACCEL_COUNT; i++) begin
        st_q[i]   <= st_d[i];
        tag_q[i]  <= tag_d[i];
        err_q[i]  <= err_d[i];
        dcnt_q[i] <= dcnt_d[i];
      end
      blk_q <= match_release;
    end
  end

`ifdef SME_WATCHDOG_EN
  // Watchdog counters and the one-cycle abort strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ACCEL_COUNT; i++) wd_q[i] <= '0;
      stop_q <= '0;
    end else begin
      for (int i = 0; i < ACCEL_COUNT; i++) wd_q[i] <= wd_d[i];
      stop_q <= stop_d;
    end
  end
  assign accel_stop = stop_q;
`else
  assign accel_stop = '0;
`endif

  // Dispatch strobe: DMA descriptor and accel reload are driven in the cycle after accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q         <= '0;
      desc_valid_q  <= 1'b0;
      desc_id_q     <= '0;
      desc_addr_q   <= '0;
      desc_len_q    <= '0;
      accel_init_q  <= '0;
      accel_state_q <= '0;
    end else begin
      desc_valid_q <= accept;
      accel_init_q <= accept ? (ONE << pick_id) : '0;
      if (accept) begin
        desc_id_q     <= pick_id;
        desc_addr_q   <= s_desc_addr;
        desc_len_q    <= s_desc_len;
        accel_state_q <= s_desc_state;
        ptr_q         <= (pick_id == IDW'(ACCEL_COUNT - 1)) ? '0 : pick_id + 1'b1;
      end
    end
  end

  // Result slot: load the arbiter winner when empty or consumed, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q      <= '0;
      res_src_q   <= '0;
      res_valid_q <= 1'b0;
      res_tag_q   <= '0;
      res_rule_q  <= '0;
      res_last_q  <= 1'b0;
      res_err_q   <= 1'b0;
    end else if (res_load) begin
      res_valid_q <= gnt_vld;
      if (gnt_vld) begin
        res_src_q <= gnt_id;
        res_tag_q <= tag_q[gnt_id];
        rptr_q    <= (gnt_id == IDW'(ACCEL_COUNT - 1)) ? '0 : gnt_id + 1'b1;
        if (gnt_final) begin
          res_rule_q <= '0;
          res_last_q <= 1'b1;
          res_err_q  <= err_q[gnt_id];
        end else begin
          res_rule_q <= match_rule_id[gnt_id*RULE_WIDTH +: RULE_WIDTH];
          res_last_q <= 1'b0;
          res_err_q  <= 1'b0;
        end
      end
    end
  end

  assign desc_valid    = desc_valid_q;
  assign desc_accel_id = desc_id_q;
  assign desc_addr     = desc_addr_q;
  assign desc_len      = desc_len_q;
  assign accel_init    = accel_init_q;
  assign accel_state   = accel_state_q;
  assign m_res_valid   = res_valid_q;
  assign m_res_tag     = res_tag_q;
  assign m_res_rule    = res_rule_q;
  assign m_res_last    = res_last_q;
  assign m_res_err     = res_err_q;

endmodule

// File: tb/tb_sme_desc_scheduler.sv
// Directed bench for sme_desc_scheduler (ACCEL_COUNT=4, DRAIN_CYCLES=16, TIMEOUT_CYCLES=64).
// A tiny SME model pops pending matches on match_release; results and dispatches are logged.
// Build with SME_WATCHDOG_EN to exercise the timeout path.
module tb_sme_desc_scheduler;
  localparam int AC = 4, AW = 16, LW = 14, TW = 8, RW = 16, DC = 16, TO = 64;
  typedef logic [TW+RW+1:0] rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] s_desc_addr;
  logic [LW-1:0] s_desc_len;
  logic [63:0]   s_desc_state;
  logic [TW-1:0] s_desc_tag;
  logic          s_desc_valid, s_desc_ready;
  logic [1:0]    desc_accel_id;
  logic [AW-1:0] desc_addr;
  logic [LW-1:0] desc_len;
  logic          desc_valid;
  logic [AC-1:0] desc_error, accel_busy, accel_done, accel_init, accel_stop;
  logic [AC-1:0] match_valid, match_release;
  logic [63:0]   accel_state;
  logic [AC*RW-1:0] match_rule_id;
  logic [TW-1:0] m_res_tag;
  logic [RW-1:0] m_res_rule;
  logic          m_res_last, m_res_err, m_res_valid, m_res_ready;

  int checks = 0;
  int errors = 0;
  int posted [AC];
  int rel_cnt [AC] = '{0, 0, 0, 0};
  logic [RW-1:0] rule_val [AC];
  rec_t       rec_q [$];
  logic [1:0] disp_q [$];

  sme_desc_scheduler #(
    .ACCEL_COUNT(AC), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TAG_WIDTH(TW),
    .RULE_WIDTH(RW), .DRAIN_CYCLES(DC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .s_desc_addr(s_desc_addr), .s_desc_len(s_desc_len), .s_desc_state(s_desc_state),
    .s_desc_tag(s_desc_tag), .s_desc_valid(s_desc_valid), .s_desc_ready(s_desc_ready),
    .desc_accel_id(desc_accel_id), .desc_addr(desc_addr), .desc_len(desc_len),
    .desc_valid(desc_valid), .desc_error(desc_error), .accel_busy(accel_busy),
    .accel_done(accel_done), .accel_init(accel_init), .accel_state(accel_state),
    .accel_stop(accel_stop), .match_valid(match_valid), .match_rule_id(match_rule_id),
    .match_release(match_release), .m_res_tag(m_res_tag), .m_res_rule(m_res_rule),
    .m_res_last(m_res_last), .m_res_err(m_res_err), .m_res_valid(m_res_valid),
    .m_res_ready(m_res_ready)
  );

  // SME model: a match stays pending until popped by match_release
  for (genvar g = 0; g < AC; g++) begin : g_sme
    assign match_valid[g]            = posted[g] > rel_cnt[g];
    assign match_rule_id[g*RW +: RW] = rule_val[g];
  end
  always @(posedge clk) begin
    for (int i = 0; i < AC; i++) if (match_release[i]) rel_cnt[i] <= rel_cnt[i] + 1;
  end

  // logs of accepted result records and DMA dispatches
  always @(negedge clk) begin
    if (!rst && m_res_valid && m_res_ready)
      rec_q.push_back({m_res_tag, m_res_rule, m_res_last, m_res_err});
    if (desc_valid) disp_q.push_back(desc_accel_id);
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_desc_valid = 1'b0;
    desc_error = '0; accel_busy = '0; accel_done = '0;
    m_res_ready = 1'b1;
    for (int i = 0; i < AC; i++) rule_val[i] = '0;
    tick();
    for (int i = 0; i < AC; i++) posted[i] = rel_cnt[i];
    tick();
    rst = 1'b0;
  endtask

  task automatic send_desc(input logic [AW-1:0] a, input logic [LW-1:0] l,
                           input logic [63:0] s, input logic [TW-1:0] t);
    int n;
    n = 0;
    s_desc_addr = a; s_desc_len = l; s_desc_state = s; s_desc_tag = t;
    s_desc_valid = 1'b1;
    @(negedge clk);
    while (!s_desc_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout: tag %h never accepted, ready=%b required 1", t, s_desc_ready);
    end
    @(posedge clk);
    #1;
    s_desc_valid = 1'b0;
  endtask

  task automatic wait_recs(input int n, input int budget);
    int k;
    k = 0;
    while (rec_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (rec_q.size() < n) begin
      checks++; errors++;
      $display("FAIL rec_timeout: got %0d records, required %0d", rec_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_desc_valid = 1'b0; s_desc_addr = '0; s_desc_len = '0; s_desc_state = '0; s_desc_tag = '0;
    desc_error = '0; accel_busy = '0; accel_done = '0; m_res_ready = 1'b1;
    for (int i = 0; i < AC; i++) begin posted[i] = 0; rule_val[i] = '0; end
    tick(); tick();
    @(negedge clk);
    checks++;
    if ({s_desc_ready, desc_valid, accel_init, accel_stop, match_release, m_res_valid,
         m_res_tag, m_res_rule, m_res_last, m_res_err, desc_addr, desc_len, desc_accel_id,
         accel_state} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b dv=%b init=%b stop=%b rel=%b rv=%b tag=%h, required all 0",
               s_desc_ready, desc_valid, accel_init, accel_stop, match_release, m_res_valid, m_res_tag);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_desc_ready !== 1'b1 || m_res_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b rv=%b, required 1/0", s_desc_ready, m_res_valid);
    end
    tick();
  endtask

  task automatic test_single();
    int rb, r0;
    do_reset();
    rb = rec_q.size(); r0 = rel_cnt[0];
    send_desc(16'h0100, 14'd64, 64'h0123_4567_89AB_CDEF, 8'h11);
    @(negedge clk);
    checks++;
    if (desc_valid !== 1'b1 || desc_accel_id !== 2'd0 || desc_addr !== 16'h0100 || desc_len !== 14'd64 ||
        accel_init !== 4'b0001 || accel_state !== 64'h0123_4567_89AB_CDEF) begin
      errors++;
      $display("FAIL single_issue: dv=%b id=%0d addr=%h len=%0d init=%b st=%h, required 1/0/0100/64/0001/0123456789abcdef",
               desc_valid, desc_accel_id, desc_addr, desc_len, accel_init, accel_state);
    end
    tick();
    rule_val[0] = 16'h0042; posted[0]++; accel_done[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (desc_valid !== 1'b0 || accel_init !== 4'b0000) begin
      errors++;
      $display("FAIL single_strobe_width: dv=%b init=%b, required 0/0000", desc_valid, accel_init);
    end
    tick();
    accel_done[0] = 1'b0;
    wait_recs(rb + 2, 100);
    checks++;
    if (rec_q[rb] !== {8'h11, 16'h0042, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_match_rec: got %h, required %h", rec_q[rb], {8'h11, 16'h0042, 1'b0, 1'b0});
    end
    checks++;
    if (rec_q[rb+1] !== {8'h11, 16'h0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_final_rec: got %h, required %h", rec_q[rb+1], {8'h11, 16'h0000, 1'b1, 1'b0});
    end
    repeat (10) tick();
    checks++;
    if (rel_cnt[0] - r0 !== 1 || rec_q.size() - rb !== 2) begin
      errors++;
      $display("FAIL single_counts: releases=%0d records=%0d, required 1/2", rel_cnt[0] - r0, rec_q.size() - rb);
    end
  endtask

  task automatic test_back_to_back();
    int db, n, bad;
    do_reset();
    db = disp_q.size();
    for (int t = 0; t < 4; t++) send_desc(AW'(t * 64), 14'd64, 64'h0, TW'(8'h20 + t));
    s_desc_tag = 8'h24; s_desc_addr = 16'h0400; s_desc_valid = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (s_desc_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_stall: ready high in %0d of 5 cycles, required 0", bad);
    end
    tick();
    accel_done = 4'b0100;
    tick();
    accel_done = '0;
    n = 0;
    @(negedge clk);
    while (!s_desc_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (s_desc_ready !== 1'b1 || m_res_valid !== 1'b1 || m_res_last !== 1'b1 || m_res_tag !== 8'h22) begin
      errors++;
      $display("FAIL b2b_free_on_final: ready=%b rv=%b last=%b tag=%h, required 1/1/1/22",
               s_desc_ready, m_res_valid, m_res_last, m_res_tag);
    end
    @(posedge clk);
    #1;
    s_desc_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (desc_valid !== 1'b1 || desc_accel_id !== 2'd2 || accel_init !== 4'b0100) begin
      errors++;
      $display("FAIL b2b_fifth: dv=%b id=%0d init=%b, required 1/2/0100", desc_valid, desc_accel_id, accel_init);
    end
    checks++;
    if ({disp_q[db+3], disp_q[db+2], disp_q[db+1], disp_q[db]} !== 8'b11_10_01_00) begin
      errors++;
      $display("FAIL b2b_order: ids %0d,%0d,%0d,%0d, required 0,1,2,3",
               disp_q[db], disp_q[db+1], disp_q[db+2], disp_q[db+3]);
    end
    tick();
  endtask

  task automatic test_desc_error();
    int rb;
    do_reset();
    accel_busy = 4'b1011;
    rb = rec_q.size();
    send_desc(16'h0800, 14'd100, 64'h5, 8'h33);
    @(negedge clk);
    checks++;
    if (desc_valid !== 1'b1 || desc_accel_id !== 2'd2) begin
      errors++;
      $display("FAIL err_pick: dv=%b id=%0d, required 1/2", desc_valid, desc_accel_id);
    end
    tick();
    desc_error = 4'b0100;
    tick();
    desc_error = '0;
    @(negedge clk);
    checks++;
    if (s_desc_ready !== 1'b0) begin
      errors++;
      $display("FAIL err_busy: ready=%b, required 0", s_desc_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (m_res_valid !== 1'b1 || {m_res_tag, m_res_rule, m_res_last, m_res_err} !== {8'h33, 16'h0, 1'b1, 1'b1} ||
        s_desc_ready !== 1'b1) begin
      errors++;
      $display("FAIL err_record: rv=%b rec=%h ready=%b, required 1/%h/1", m_res_valid,
               {m_res_tag, m_res_rule, m_res_last, m_res_err}, s_desc_ready, {8'h33, 16'h0, 1'b1, 1'b1});
    end
    repeat (20) tick();
    checks++;
    if (rec_q.size() - rb !== 1) begin
      errors++;
      $display("FAIL err_count: got %0d records, required 1", rec_q.size() - rb);
    end
    accel_busy = '0;
  endtask

  task automatic test_backpressure();
    int rb, r0, r1, r2, bad;
    do_reset();
    m_res_ready = 1'b0;
    rb = rec_q.size(); r0 = rel_cnt[0]; r1 = rel_cnt[1]; r2 = rel_cnt[2];
    for (int t = 0; t < 3; t++) send_desc(AW'(t * 256), 14'd32, 64'h0, TW'(8'h40 + t));
    for (int i = 0; i < 3; i++) begin rule_val[i] = RW'(16'h00A0 + i); posted[i]++; end
    tick();
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_res_valid !== 1'b1 || m_res_tag !== 8'h40 || m_res_rule !== 16'h00A0 || m_res_last !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_stable: held record wrong in %0d of 20 cycles (tag=%h rule=%h), required 40/00a0",
               bad, m_res_tag, m_res_rule);
    end
    checks++;
    if (rel_cnt[0] - r0 !== 1 || rel_cnt[1] - r1 !== 0 || rel_cnt[2] - r2 !== 0) begin
      errors++;
      $display("FAIL bp_release_hold: releases %0d,%0d,%0d, required 1,0,0",
               rel_cnt[0] - r0, rel_cnt[1] - r1, rel_cnt[2] - r2);
    end
    tick();
    m_res_ready = 1'b1;
    accel_done = 4'b0111;
    tick();
    accel_done = '0;
    wait_recs(rb + 6, 200);
    checks++;
    if ({rec_q[rb], rec_q[rb+1], rec_q[rb+2]} !==
        {8'h40, 16'h00A0, 2'b00, 8'h41, 16'h00A1, 2'b00, 8'h42, 16'h00A2, 2'b00}) begin
      errors++;
      $display("FAIL bp_rr_order: got %h %h %h, required tags 40,41,42 rules a0,a1,a2",
               rec_q[rb], rec_q[rb+1], rec_q[rb+2]);
    end
    checks++;
    if (rec_q[rb+3][1] !== 1'b1 || rec_q[rb+4][1] !== 1'b1 || rec_q[rb+5][1] !== 1'b1 ||
        rel_cnt[0] - r0 !== 1 || rel_cnt[1] - r1 !== 1 || rel_cnt[2] - r2 !== 1) begin
      errors++;
      $display("FAIL bp_finals: recs %h %h %h releases %0d,%0d,%0d, required last=1 x3 and 1,1,1",
               rec_q[rb+3], rec_q[rb+4], rec_q[rb+5], rel_cnt[0] - r0, rel_cnt[1] - r1, rel_cnt[2] - r2);
    end
  endtask

  task automatic test_drain_restart();
    int rb;
    do_reset();
    rb = rec_q.size();
    send_desc(16'h1000, 14'd80, 64'h0, 8'h50);
    tick();
    accel_done[0] = 1'b1;
    tick();
    accel_done[0] = 1'b0;
    repeat (10) tick();
    checks++;
    if (rec_q.size() !== rb) begin
      errors++;
      $display("FAIL drain_early: %0d records before drain expiry, required 0", rec_q.size() - rb);
    end
    rule_val[0] = 16'h0077; posted[0]++;
    wait_recs(rb + 2, 100);
    checks++;
    if (rec_q[rb] !== {8'h50, 16'h0077, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL drain_match_rec: got %h, required %h", rec_q[rb], {8'h50, 16'h0077, 1'b0, 1'b0});
    end
    checks++;
    if (rec_q[rb+1] !== {8'h50, 16'h0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL drain_final_rec: got %h, required %h", rec_q[rb+1], {8'h50, 16'h0000, 1'b1, 1'b0});
    end
  endtask

`ifdef SME_WATCHDOG_EN
  task automatic test_watchdog();
    int rb, k;
    do_reset();
    rb = rec_q.size();
    send_desc(16'h2000, 14'd64, 64'h0, 8'h60);
    k = 0;
    @(negedge clk);
    while (accel_stop[0] !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k !== TO || accel_stop !== 4'b0001) begin
      errors++;
      $display("FAIL wd_stop_time: stop=%b at cycle %0d, required 0001 at %0d", accel_stop, k, TO);
    end
    @(negedge clk);
    checks++;
    if (accel_stop !== 4'b0000) begin
      errors++;
      $display("FAIL wd_stop_width: stop=%b, required 0000", accel_stop);
    end
    wait_recs(rb + 1, 20);
    checks++;
    if (rec_q[rb] !== {8'h60, 16'h0000, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL wd_record: got %h, required %h", rec_q[rb], {8'h60, 16'h0000, 1'b1, 1'b1});
    end
  endtask
`else
  task automatic test_watchdog();
    int rb, bad;
    do_reset();
    rb = rec_q.size();
    send_desc(16'h2000, 14'd64, 64'h0, 8'h60);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (accel_stop !== 4'b0000) bad++;
    end
    checks++;
    if (bad != 0 || rec_q.size() !== rb) begin
      errors++;
      $display("FAIL nowd_quiet: stop high %0d cycles, %0d records, required 0/0", bad, rec_q.size() - rb);
    end
    tick();
  endtask
`endif

  task automatic test_reset_mid_job();
    int rb;
    do_reset();
    m_res_ready = 1'b0;
    send_desc(16'h3000, 14'd64, 64'hFFFF_0000_FFFF_0000, 8'h70);
    tick();
    rule_val[0] = 16'h0099; posted[0]++;
    tick();
    @(negedge clk);
    checks++;
    if (m_res_valid !== 1'b1 || m_res_rule !== 16'h0099) begin
      errors++;
      $display("FAIL midrst_setup: rv=%b rule=%h, required 1/0099", m_res_valid, m_res_rule);
    end
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({s_desc_ready, desc_valid, accel_init, accel_stop, match_release, m_res_valid,
         m_res_tag, m_res_rule, m_res_last, m_res_err, desc_addr, desc_len, desc_accel_id,
         accel_state} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: ready=%b rv=%b tag=%h rule=%h addr=%h st=%h, required all 0",
               s_desc_ready, m_res_valid, m_res_tag, m_res_rule, desc_addr, accel_state);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < AC; i++) posted[i] = rel_cnt[i];
    rb = rec_q.size();
    m_res_ready = 1'b1;
    repeat (30) tick();
    checks++;
    if (rec_q.size() !== rb || s_desc_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_abandon: %0d records after reset, ready=%b, required 0/1", rec_q.size() - rb, s_desc_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_desc_error();
    test_backpressure();
    test_drain_restart();
    test_watchdog();
    test_reset_mid_job();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
